// File: rtl/alu_sequencial_if.sv
// Start/busy/done bus between the control FSM and the sequential ALU.
// The control FSM drives through master; the ALU receives through slave.
interface alu_sequencial_if #(
  parameter int LARGURA = 8
);
  logic               inicio;
  logic [3:0]         operacao;
  logic [LARGURA-1:0] entradaA;
  logic [LARGURA-1:0] entradaB;
  logic               ocupado;
  logic               pronto;
  logic [LARGURA-1:0] resultado;
  logic [LARGURA-1:0] resultado_alto;
  logic               carry_out;
  logic               zero_flag;
  logic               negativo;
  logic               overflow;
  logic               div_zero;

  modport master (
    output inicio, operacao, entradaA, entradaB,
    input  ocupado, pronto, resultado, resultado_alto,
           carry_out, zero_flag, negativo, overflow, div_zero
  );

  modport slave (
    input  inicio, operacao, entradaA, entradaB,
    output ocupado, pronto, resultado, resultado_alto,
           carry_out, zero_flag, negativo, overflow, div_zero
  );
endinterface

// File: rtl/alu_sequencial.sv
// Parametrised ALU with registered outputs/flags: single-cycle arithmetic and logic,
// plus iterative shift-add multiply and restoring divide with double-width results.
module alu_sequencial #(
  parameter int LARGURA = 8
) (
  input logic             clk,
  input logic             rst,
  alu_sequencial_if.slave bus
);
  localparam int CNT_W = $clog2(LARGURA) + 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(LARGURA - 1);

  typedef enum logic {OCIOSO, CALC} estado_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_NOT = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9
  } op_e;

  estado_e            estado, estado_prox;
  logic [CNT_W-1:0]   cnt;
  logic [LARGURA-1:0] a_reg, b_reg;
  logic [LARGURA-1:0] hi, lo;
  logic               eh_div;

  logic aceita, inicia_iter, conclui_iter, op_longa;

  // single-cycle datapath
  logic [LARGURA:0]   soma, dif;
  logic [LARGURA-1:0] s_res;
  logic               s_carry, s_ovf;

  // iteration datapath
  logic [LARGURA:0]   soma_mul, desloc, sub_div;
  logic [LARGURA-1:0] hi_prox, lo_prox;

  // values loaded into the output registers
  logic [LARGURA-1:0] o_res, o_alto;
  logic               o_carry, o_ovf, o_dz, carrega;

  assign op_longa    = (bus.operacao == OP_MUL) || (bus.operacao == OP_DIV);
  assign bus.ocupado = (estado == CALC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= OCIOSO;
    else     estado <= estado_prox;
  end

  always_comb begin
    estado_prox  = estado;
    aceita       = 1'b0;
    inicia_iter  = 1'b0;
    conclui_iter = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.inicio) begin
          aceita = 1'b1;
          if (op_longa) begin
            inicia_iter = 1'b1;
            estado_prox = CALC;
          end
        end
      end
      CALC: begin
        if (cnt == ULTIMO) begin
          conclui_iter = 1'b1;
          estado_prox  = OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  always_comb begin
    soma    = {1'b0, bus.entradaA} + {1'b0, bus.entradaB};
    dif     = {1'b0, bus.entradaA} - {1'b0, bus.entradaB};
    s_res   = '0;
    s_carry = 1'b0;
    s_ovf   = 1'b0;
    case (bus.operacao)
      OP_ADD: begin
        s_res   = soma[LARGURA-1:0];
        s_carry = soma[LARGURA];
        s_ovf   = (bus.entradaA[LARGURA-1] == bus.entradaB[LARGURA-1]) &&
                  (soma[LARGURA-1] != bus.entradaA[LARGURA-1]);
      end
      OP_SUB: begin
        s_res   = dif[LARGURA-1:0];
        s_carry = dif[LARGURA];
        s_ovf   = (bus.entradaA[LARGURA-1] != bus.entradaB[LARGURA-1]) &&
                  (dif[LARGURA-1] != bus.entradaA[LARGURA-1]);
      end
      OP_AND: s_res = bus.entradaA & bus.entradaB;
      OP_OR:  s_res = bus.entradaA | bus.entradaB;
      OP_NOT: s_res = ~bus.entradaA;
      OP_XOR: s_res = bus.entradaA ^ bus.entradaB;
      OP_SHL: begin
        s_res   = {bus.entradaA[LARGURA-2:0], 1'b0};
        s_carry = bus.entradaA[LARGURA-1];
      end
      OP_SHR: begin
        s_res   = {1'b0, bus.entradaA[LARGURA-1:1]};
        s_carry = bus.entradaA[0];
      end
      default: s_res = '0;
    endcase
  end

  // hi/lo are shared: MUL keeps {partial product, remaining multiplier},
  // DIV keeps {partial remainder, dividend shifting into quotient}.
  always_comb begin
    soma_mul = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
    desloc   = {hi, lo[LARGURA-1]};
    sub_div  = desloc - {1'b0, b_reg};
    hi_prox  = hi;
    lo_prox  = lo;
    if (eh_div) begin
      if (desloc >= {1'b0, b_reg}) begin
        hi_prox = sub_div[LARGURA-1:0];
        lo_prox = {lo[LARGURA-2:0], 1'b1};
      end else begin
        hi_prox = desloc[LARGURA-1:0];
        lo_prox = {lo[LARGURA-2:0], 1'b0};
      end
    end else begin
      hi_prox = soma_mul[LARGURA:1];
      lo_prox = {soma_mul[0], lo[LARGURA-1:1]};
    end
  end

  always_comb begin
    carrega = (aceita && !inicia_iter) || conclui_iter;
    o_res   = s_res;
    o_alto  = '0;
    o_carry = s_carry;
    o_ovf   = s_ovf;
    o_dz    = 1'b0;
    if (conclui_iter) begin
      o_ovf = 1'b0;
      if (eh_div) begin
        o_carry = 1'b0;
        if (b_reg == '0) begin
          o_res  = '1;
          o_alto = a_reg;
          o_dz   = 1'b1;
        end else begin
          o_res  = lo_prox;
          o_alto = hi_prox;
        end
      end else begin
        o_res   = lo_prox;
        o_alto  = hi_prox;
        o_carry = |hi_prox;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt                <= '0;
      a_reg              <= '0;
      b_reg              <= '0;
      hi                 <= '0;
      lo                 <= '0;
      eh_div             <= 1'b0;
      bus.pronto         <= 1'b0;
      bus.resultado      <= '0;
      bus.resultado_alto <= '0;
      bus.carry_out      <= 1'b0;
      bus.zero_flag      <= 1'b0;
      bus.negativo       <= 1'b0;
      bus.overflow       <= 1'b0;
      bus.div_zero       <= 1'b0;
    end else begin
      bus.pronto <= carrega;
      if (inicia_iter) begin
        a_reg  <= bus.entradaA;
        b_reg  <= bus.entradaB;
        hi     <= '0;
        lo     <= bus.entradaA;
        eh_div <= (bus.operacao == OP_DIV);
        cnt    <= '0;
      end else if (estado == CALC) begin
        hi  <= hi_prox;
        lo  <= lo_prox;
        cnt <= cnt + CNT_W'(1);
      end
      if (carrega) begin
        bus.resultado      <= o_res;
        bus.resultado_alto <= o_alto;
        bus.carry_out      <= o_carry;
        bus.zero_flag      <= ({o_alto, o_res} == '0);
        bus.negativo       <= o_res[LARGURA-1];
        bus.overflow       <= o_ovf;
        bus.div_zero       <= o_dz;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencial.sv
// Directed bench for alu_sequencial at LARGURA=8 and LARGURA=16.
module tb_alu_sequencial;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencial_if #(.LARGURA(8))  bus8 ();
  alu_sequencial_if #(.LARGURA(16)) bus16 ();

  alu_sequencial #(.LARGURA(8))  u8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  alu_sequencial #(.LARGURA(16)) u16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int checks = 0;
  int errors = 0;
  int n;
  int seen;

  logic [22:0] all8;
  logic [38:0] all16;
  assign all8  = {bus8.pronto, bus8.ocupado, bus8.carry_out, bus8.zero_flag, bus8.negativo,
                  bus8.overflow, bus8.div_zero, bus8.resultado_alto, bus8.resultado};
  assign all16 = {bus16.pronto, bus16.ocupado, bus16.carry_out, bus16.zero_flag, bus16.negativo,
                  bus16.overflow, bus16.div_zero, bus16.resultado_alto, bus16.resultado};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // returns #1 after the start edge with inicio dropped
  task automatic start8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.inicio   = 1'b1;
    bus8.operacao = op;
    bus8.entradaA = a;
    bus8.entradaB = b;
    @(posedge clk);
    #1;
    bus8.inicio = 1'b0;
  endtask

  task automatic wait8(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (bus8.pronto !== 1'b1 && cnt < 40);
  endtask

  initial begin
    rst = 1'b1;
    bus8.inicio = 1'b0;  bus8.operacao = 4'h0;  bus8.entradaA = '0;  bus8.entradaB = '0;
    bus16.inicio = 1'b0; bus16.operacao = 4'h0; bus16.entradaA = '0; bus16.entradaB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset8_outputs", 64'(all8), 64'h0);
    chk("reset16_outputs", 64'(all16), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // ADD 200+100
    start8(4'h0, 8'd200, 8'd100);
    chk("add_pronto", 64'(bus8.pronto), 64'h1);
    chk("add_res", 64'(bus8.resultado), 64'h2C);
    chk("add_carry", 64'(bus8.carry_out), 64'h1);
    chk("add_zero", 64'(bus8.zero_flag), 64'h0);
    chk("add_ovf", 64'(bus8.overflow), 64'h0);
    @(posedge clk);
    #1;
    chk("pronto_width", 64'(bus8.pronto), 64'h0);
    chk("add_hold", 64'(bus8.resultado), 64'h2C);

    // SUB 5-7
    start8(4'h1, 8'd5, 8'd7);
    chk("sub_res", 64'(bus8.resultado), 64'hFE);
    chk("sub_borrow", 64'(bus8.carry_out), 64'h1);
    chk("sub_neg", 64'(bus8.negativo), 64'h1);
    chk("sub_ovf", 64'(bus8.overflow), 64'h0);

    // ADD 0x7F+0x01
    start8(4'h0, 8'h7F, 8'h01);
    chk("addov_res", 64'(bus8.resultado), 64'h80);
    chk("addov_ovf", 64'(bus8.overflow), 64'h1);
    chk("addov_neg", 64'(bus8.negativo), 64'h1);
    chk("addov_carry", 64'(bus8.carry_out), 64'h0);

    // SUB 9-9
    start8(4'h1, 8'd9, 8'd9);
    chk("subz_res", 64'(bus8.resultado), 64'h00);
    chk("subz_zero", 64'(bus8.zero_flag), 64'h1);
    chk("subz_borrow", 64'(bus8.carry_out), 64'h0);

    // NOP opcode
    start8(4'hF, 8'd5, 8'd3);
    chk("nop_res", 64'({bus8.resultado_alto, bus8.resultado}), 64'h0);
    chk("nop_zero", 64'(bus8.zero_flag), 64'h1);

    // MUL 200*3 with an ignored start request while busy
    start8(4'h8, 8'd200, 8'd3);
    chk("mul_busy", 64'(bus8.ocupado), 64'h1);
    chk("mul_no_early_pronto", 64'(bus8.pronto), 64'h0);
    @(negedge clk);
    bus8.inicio = 1'b1; bus8.operacao = 4'h0; bus8.entradaA = 8'd1; bus8.entradaB = 8'd1;
    @(posedge clk);
    #1;
    bus8.inicio = 1'b0;
    chk("mul_busy_after_ignored", 64'(bus8.ocupado), 64'h1);
    wait8(n);
    chk("mul_latency", 64'(n + 1), 64'd8);
    chk("mul_res", 64'(bus8.resultado), 64'h58);
    chk("mul_alto", 64'(bus8.resultado_alto), 64'h02);
    chk("mul_carry", 64'(bus8.carry_out), 64'h1);
    chk("mul_idle", 64'(bus8.ocupado), 64'h0);
    @(posedge clk);
    #1;
    chk("mul_no_queued", 64'(bus8.pronto), 64'h0);
    chk("mul_hold", 64'(bus8.resultado), 64'h58);

    // DIV 100/7, operands changed after the start edge
    start8(4'h9, 8'd100, 8'd7);
    bus8.entradaA = 8'd0;
    bus8.entradaB = 8'd0;
    wait8(n);
    chk("div_latency", 64'(n), 64'd8);
    chk("div_quot", 64'(bus8.resultado), 64'd14);
    chk("div_rem", 64'(bus8.resultado_alto), 64'd2);
    chk("div_dz", 64'(bus8.div_zero), 64'h0);
    chk("div_carry", 64'(bus8.carry_out), 64'h0);

    // DIV 55/0
    start8(4'h9, 8'd55, 8'd0);
    wait8(n);
    chk("div0_latency", 64'(n), 64'd8);
    chk("div0_quot", 64'(bus8.resultado), 64'hFF);
    chk("div0_rem", 64'(bus8.resultado_alto), 64'd55);
    chk("div0_dz", 64'(bus8.div_zero), 64'h1);

    // ADD 1+1 clears div_zero
    start8(4'h0, 8'd1, 8'd1);
    chk("clr_res", 64'(bus8.resultado), 64'h02);
    chk("clr_dz", 64'(bus8.div_zero), 64'h0);

    // reset three cycles into a MUL
    start8(4'h8, 8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", 64'(all8), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus8.pronto === 1'b1) seen++;
    end
    chk("abandoned_no_pronto", 64'(seen), 64'd0);
    chk("abandoned_idle", 64'(bus8.ocupado), 64'h0);

    // MUL 15*15
    start8(4'h8, 8'd15, 8'd15);
    wait8(n);
    chk("mul15_latency", 64'(n), 64'd8);
    chk("mul15_res", 64'(bus8.resultado), 64'hE1);
    chk("mul15_alto", 64'(bus8.resultado_alto), 64'h00);
    chk("mul15_carry", 64'(bus8.carry_out), 64'h0);

    // back-to-back with inicio held high
    @(negedge clk);
    bus8.inicio = 1'b1; bus8.operacao = 4'h2; bus8.entradaA = 8'hF0; bus8.entradaB = 8'h3C;
    @(posedge clk);
    #1;
    chk("b2b_and_pronto", 64'(bus8.pronto), 64'h1);
    chk("b2b_and_res", 64'(bus8.resultado), 64'h30);
    bus8.operacao = 4'h6; bus8.entradaA = 8'h81;
    @(posedge clk);
    #1;
    bus8.inicio = 1'b0;
    chk("b2b_shl_pronto", 64'(bus8.pronto), 64'h1);
    chk("b2b_shl_res", 64'(bus8.resultado), 64'h02);
    chk("b2b_shl_carry", 64'(bus8.carry_out), 64'h1);

    // LARGURA=16 MUL 0xFFFF*0xFFFF
    @(negedge clk);
    bus16.inicio = 1'b1; bus16.operacao = 4'h8; bus16.entradaA = 16'hFFFF; bus16.entradaB = 16'hFFFF;
    @(posedge clk);
    #1;
    bus16.inicio = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus16.pronto !== 1'b1 && n < 60);
    chk("mul16_latency", 64'(n), 64'd16);
    chk("mul16_res", 64'(bus16.resultado), 64'h0001);
    chk("mul16_alto", 64'(bus16.resultado_alto), 64'hFFFE);
    chk("mul16_carry", 64'(bus16.carry_out), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_sequencial.md
Name: alu_sequencial

Overview:
- Parametrised successor to the 8-bit combinational ALU unit.
- Operand width is configurable. Outputs and flags are registered.
- Adds an iterative shift-add multiplier and a restoring divider that both return a double-width result.
- Sits between the register file and the write-back stage. It is driven by the control FSM through a start/busy/done handshake.

Parameters:
- LARGURA, 8, operand and result width in bits (valid values ≥ 4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- inicio  input  1  start request; operands and opcode are sampled on the rising edge where inicio=1 and ocupado=0.
- operacao  input  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOT A, 0101 XOR, 0110 SHL1, 0111 SHR1 (logical), 1000 MUL (unsigned), 1001 DIV (unsigned), others = NOP result 0.
- entradaA  input  LARGURA  operand A.
- entradaB  input  LARGURA  operand B.
- ocupado  output  1  high while a MUL or DIV is iterating.
- pronto  output  1  one-cycle pulse: the result and flag outputs were updated on the preceding edge.
- resultado  output  LARGURA  low result: sum, difference, logic result, product low half, or quotient.
- resultado_alto  output  LARGURA  product high half or remainder; 0 for all other ops.
- carry_out  output  1  carry/borrow/shift-out/product-overflow (see Behaviour).
- zero_flag  output  1  the full result is zero.
- negativo  output  1  resultado[LARGURA-1].
- overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
- div_zero  output  1  the last DIV had entradaB = 0.

Behaviour:
- Reset (asynchronous, any time): all outputs go to 0, the FSM goes to OCIOSO, and internal iteration registers are cleared.
  - An in-flight MUL/DIV is abandoned and produces no pronto.
- FSM states: OCIOSO, CALC.
  - OCIOSO, inicio=1, single-cycle op: compute on that edge and register the outputs. pronto=1 in the next cycle. Stay in OCIOSO. Latency is 1.
  - OCIOSO, inicio=1, MUL or DIV: latch the operands and clear the counter. Go to CALC. ocupado=1 from the next cycle.
  - CALC: one iteration per edge, LARGURA iterations in total.
    - On the final iteration edge, register the outputs, set pronto=1, drop ocupado, and return to OCIOSO.
    - Start edge = edge 0. Result edge = edge LARGURA. Latency is LARGURA cycles.
- inicio while ocupado=1 is ignored: no queuing, no effect on the operation in flight.
- Back-to-back: inicio in the same cycle that pronto=1 is accepted normally.
- Operand or opcode changes after the start edge have no effect on the operation in flight.
- Outputs hold their values between completions. pronto is exactly one cycle wide.
- Flag rules (W = LARGURA):
  - ADD: carry_out = bit W of A+B. overflow = (A[W-1]==B[W-1]) && (R[W-1]!=A[W-1]).
  - SUB: carry_out = borrow (A<B, unsigned). overflow = (A[W-1]!=B[W-1]) && (R[W-1]!=A[W-1]).
  - SHL1: carry_out = A[W-1]. SHR1: carry_out = A[0]. Vacated bit = 0.
  - MUL: {resultado_alto, resultado} = A*B over 2W bits. carry_out = |resultado_alto.
  - DIV: resultado = A/B, resultado_alto = A%B, carry_out = 0.
  - DIV by zero: resultado = all ones, resultado_alto = A, div_zero=1. Still takes the full LARGURA cycles.
  - Logic ops and NOP: carry_out = 0, overflow = 0.
  - zero_flag = ({resultado_alto, resultado} == 0). negativo = MSB of resultado, for every op.
  - div_zero is cleared by any completion other than DIV by zero.
- Iteration counter width is clog2(LARGURA)+1. There is no wrap-around on the counter; it terminates exactly at LARGURA.

Test Plan:
- LARGURA=8, reset mid-stream: all outputs 0. Then ADD 200+100 -> resultado=0x2C, carry_out=1, zero=0, pronto 1 cycle after the start edge.
- SUB 5-7 -> 0xFE, carry_out=1, negativo=1, overflow=0. ADD 0x7F+0x01 -> 0x80, overflow=1, negativo=1. SUB 9-9 -> 0, zero_flag=1.
- MUL 200*3 -> resultado=0x58, resultado_alto=0x02, carry_out=1. ocupado=1 for 8 cycles; pronto exactly 8 edges after start. A second inicio during ocupado is ignored and the result is unchanged.
- DIV 100/7 -> resultado=14, resultado_alto=2, div_zero=0. DIV 55/0 -> resultado=0xFF, resultado_alto=55, div_zero=1. The following ADD 1+1 clears div_zero.
- Assert rst 3 cycles into a MUL: outputs 0 immediately (asynchronous), no pronto. After release, MUL 15*15 -> 0xE1 / 0x00, carry_out=0.
- Back-to-back: inicio held high across ops (AND 0xF0&0x3C, then SHL1 0x81). Expect 0x30, then 0x02 with carry_out=1, in consecutive pronto pulses. Repeat MUL at LARGURA=16: 0xFFFF*0xFFFF -> 0x0001 / 0xFFFE, 16-cycle latency.
